// File: rtl/hop_seq_pkg.sv
// Shared constants for the hop chain sequencer: default sizing and FSM state codes.
package hop_seq_pkg;

  localparam int DEF_NUM_CHAINS  = 4;
  localparam int DEF_CHAIN_DEPTH = 7;
  localparam int DEF_RST_HOLD    = 4;
  localparam int DEF_TIMEOUT     = 15;

  // Stages 2..CHAIN_DEPTH of each chain are the ones whose resets we drive.
  localparam int STAGES = DEF_CHAIN_DEPTH - 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HOLD    = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_READY   = 3'd3;
  localparam logic [2:0] ST_LAUNCH  = 3'd4;
  localparam logic [2:0] ST_WAIT    = 3'd5;
  localparam logic [2:0] ST_CHECK   = 3'd6;
  localparam logic [2:0] ST_ERR     = 3'd7;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hop_rr_arbiter.sv
// Round-robin picker: lowest requesting index at or after ptr, wrapping around.
module hop_rr_arbiter
  import hop_seq_pkg::*;
#(
  parameter int N = DEF_NUM_CHAINS,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  localparam logic [IW:0] N_W = (IW + 1)'(N);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Scan candidates starting at ptr; the first requester found wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW + 1)'(i);
      if (sum >= N_W) sum = sum - N_W;
      cand = sum[IW-1:0];
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/hop_chain_sequencer.sv
// Hop chain sequencer: staggered stage-reset release, round-robin token launch,
// and arrival-latency checking for a bank of single-bit hop chains.
module hop_chain_sequencer
  import hop_seq_pkg::*;
#(
  parameter int NUM_CHAINS  = DEF_NUM_CHAINS,
  parameter int CHAIN_DEPTH = DEF_CHAIN_DEPTH,
  parameter int RST_HOLD    = DEF_RST_HOLD,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  localparam int CW         = idx_width(NUM_CHAINS),
  localparam int NUM_STAGES = CHAIN_DEPTH - 1
) (
  input  logic                             clock0,
  input  logic                             rst1,
  input  logic                             go,
  input  logic [NUM_CHAINS-1:0]            req,
  input  logic [NUM_CHAINS-1:0]            chain_out,
  output logic [NUM_CHAINS*NUM_STAGES-1:0] stage_rst,
  output logic [NUM_CHAINS-1:0]            start,
  output logic [NUM_CHAINS-1:0]            grant,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [CW-1:0]                    err_chain
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int HW = idx_width(RST_HOLD);
  localparam int RW = idx_width(NUM_STAGES);

  localparam logic [WW-1:0] CNT_ARRIVE = WW'(CHAIN_DEPTH);
  localparam logic [WW-1:0] CNT_LIMIT  = WW'(TIMEOUT);
  localparam logic [WW-1:0] CNT_MAX    = {WW{1'b1}};
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD - 1);
  localparam logic [RW-1:0] REL_LAST   = RW'(NUM_STAGES - 1);
  localparam logic [CW-1:0] LAST_CHAIN = CW'(NUM_CHAINS - 1);

  logic [2:0]            state;
  logic [HW-1:0]         hold_cnt;
  logic [RW-1:0]         rel_idx;
  logic [WW-1:0]         wait_cnt;
  logic [CW-1:0]         rr_ptr;
  logic [CW-1:0]         cur_idx;
  logic [NUM_CHAINS-1:0] cur_grant;
  logic                  err_q;
  logic [CW-1:0]         err_chain_q;

  logic [NUM_CHAINS-1:0] arb_grant;
  logic [CW-1:0]         arb_idx;
  logic                  arb_valid;
  logic [WW-1:0]         cnt_now;
  logic                  own_hit;
  logic                  stray_hit;

  hop_rr_arbiter #(.N(NUM_CHAINS)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // cnt_now is the wait count for the current WAIT cycle (1 on the first one).
  assign cnt_now   = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
  assign own_hit   = |(chain_out & cur_grant);
  assign stray_hit = |(chain_out & ~cur_grant);
  assign err       = err_q;
  assign err_chain = err_chain_q;

  // Sequencer FSM with its hold, release and wait counters.
  always_ff @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      rel_idx     <= '0;
      wait_cnt    <= '0;
      rr_ptr      <= '0;
      cur_idx     <= '0;
      cur_grant   <= '0;
      err_q       <= 1'b0;
      err_chain_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state   <= ST_RELEASE;
            rel_idx <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (rel_idx == REL_LAST) state <= ST_READY;
          else rel_idx <= rel_idx + 1'b1;
        end
        ST_READY: begin
          if (arb_valid) begin
            cur_idx   <= arb_idx;
            cur_grant <= arb_grant;
            rr_ptr    <= (arb_idx == LAST_CHAIN) ? '0 : arb_idx + 1'b1;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt <= cnt_now;
          if (stray_hit || (own_hit && cnt_now != CNT_ARRIVE) ||
              (!own_hit && cnt_now >= CNT_LIMIT)) begin
            state       <= ST_ERR;
            err_q       <= 1'b1;
            err_chain_q <= cur_idx;
          end else if (own_hit) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (own_hit) begin
            state       <= ST_ERR;
            err_q       <= 1'b1;
            err_chain_q <= cur_idx;
          end else begin
            state <= ST_READY;
          end
        end
        ST_ERR: begin
          if (go) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            err_q    <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs; stage resets stay asserted unless the bank is released.
  always_comb begin
    stage_rst = '1;
    start     = '0;
    grant     = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_HOLD: busy = 1'b1;
      ST_RELEASE: begin
        busy = 1'b1;
        for (int c = 0; c < NUM_CHAINS; c++)
          for (int s = 0; s < NUM_STAGES; s++)
            stage_rst[c*NUM_STAGES + s] = (RW'(s) > rel_idx);
      end
      ST_READY: stage_rst = '0;
      ST_LAUNCH: begin
        stage_rst = '0;
        start     = cur_grant;
        grant     = cur_grant;
        busy      = 1'b1;
      end
      ST_WAIT: begin
        stage_rst = '0;
        grant     = cur_grant;
        busy      = 1'b1;
      end
      ST_CHECK: begin
        stage_rst = '0;
        grant     = cur_grant;
        busy      = 1'b1;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hop_chain_sequencer.sv
// Bench for hop_chain_sequencer: models the chain bank and checks sequencing,
// arbitration, latency, error detection and mid-run reset.
module tb_hop_chain_sequencer;

  localparam int N  = 4;
  localparam int D  = 7;
  localparam int H  = 4;
  localparam int TO = 15;
  localparam int S  = D - 1;
  localparam int CW = $clog2(N);

  logic           clock0 = 1'b0;
  logic           rst1;
  logic           go;
  logic [N-1:0]   req;
  logic [N-1:0]   chain_out;
  logic [N*S-1:0] stage_rst;
  logic [N-1:0]   start;
  logic [N-1:0]   grant;
  logic           busy;
  logic           done;
  logic           err;
  logic [CW-1:0]  err_chain;

  logic [N*S-1:0] stuck_mask;
  logic [N*S-1:0] eff_rst;
  logic [N-1:0]   inj;
  logic [D-1:0]   chain_q [N];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rr_model = 0;

  hop_chain_sequencer dut (
    .clock0    (clock0),
    .rst1      (rst1),
    .go        (go),
    .req       (req),
    .chain_out (chain_out),
    .stage_rst (stage_rst),
    .start     (start),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_chain (err_chain)
  );

  // Free-running clock.
  always #5 clock0 = ~clock0;

  assign eff_rst = stage_rst | stuck_mask;

  // Chain bank: head flop on rst1, later stages cleared while their reset is high.
  always @(posedge clock0 or posedge rst1) begin
    if (rst1) begin
      for (int c = 0; c < N; c++) chain_q[c] <= '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        chain_q[c][0] <= start[c];
        for (int k = 1; k < D; k++) begin
          if (eff_rst[c*S + k - 1]) chain_q[c][k] <= 1'b0;
          else if (k == 1) chain_q[c][k] <= chain_q[c][0];
          else chain_q[c][k] <= chain_q[c][k-1] & ~eff_rst[c*S + k - 2];
        end
      end
    end
  end

  // Tail of each chain as seen by the sequencer, plus injected glitches.
  always_comb begin
    for (int c = 0; c < N; c++)
      chain_out[c] = (chain_q[c][D-1] & ~eff_rst[c*S + S - 1]) | inj[c];
  end

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v = '0;
    v[CW'(k)] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      logic [CW-1:0] j;
      j = CW'((p + i) % N);
      if (r[j]) return int'(j);
    end
    return -1;
  endfunction

  // Expected stage resets t cycles after go is taken: hold, then stage s drops in release cycle s.
  function automatic logic [N*S-1:0] exp_stage(input int t);
    logic [N*S-1:0] v;
    v = '0;
    if (t <= H) v = '1;
    else if (t <= H + S)
      for (int c = 0; c < N; c++)
        for (int s = 0; s < S; s++)
          v[c*S + s] = (s > t - H - 1);
    return v;
  endfunction

  task automatic tick();
    @(posedge clock0);
    #1;
    cyc++;
  endtask

  task automatic wait_for_start(output int at, output bit seen);
    seen = 1'b0;
    at   = cyc;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (|start) begin
        seen = 1'b1;
        at   = cyc;
        break;
      end
    end
  endtask

  task automatic wait_for_done(output int at, output bit seen);
    seen = 1'b0;
    at   = cyc;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        at   = cyc;
        break;
      end
    end
  endtask

  task automatic restart_sequence();
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (H + S) tick();
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    go = 1'b0;
    req = '0;
    inj = '0;
    stuck_mask = '0;
    repeat (2) tick();
    checks++; if (stage_rst !== '1) begin errors++; $display("[TB] FAIL reset_stage_rst: got %h expected all ones", stage_rst); end
    checks++; if (start !== '0) begin errors++; $display("[TB] FAIL reset_start: got %b expected 0", start); end
    checks++; if (grant !== '0) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0", grant); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: busy/done/err got %b expected 000", {busy, done, err}); end
    checks++; if (err_chain !== '0) begin errors++; $display("[TB] FAIL reset_err_chain: got %0d expected 0", err_chain); end
    rst1 = 1'b0;
    repeat (3) tick();
    checks++; if (stage_rst !== '1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_hold: stage_rst %h busy %b expected all ones, 0", stage_rst, busy); end
  endtask

  task automatic test_sequence();
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int t = 1; t <= H + S + 1; t++) begin
      checks++;
      if (stage_rst !== exp_stage(t)) begin
        errors++;
        $display("[TB] FAIL seq_stage_rst t=%0d: got %h expected %h", t, stage_rst, exp_stage(t));
      end
      checks++;
      if (busy !== (t <= H + S)) begin
        errors++;
        $display("[TB] FAIL seq_busy t=%0d: got %b expected %b", t, busy, (t <= H + S));
      end
      if (t < H + S + 1) tick();
    end
  endtask

  task automatic test_back_to_back();
    int  ls, ds, prev;
    bit  seen;
    prev = -1;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int w;
      w = rr_pick(req, rr_model);
      wait_for_start(ls, seen);
      checks++;
      if (!seen || start !== oh(w)) begin
        errors++;
        $display("[TB] FAIL b2b_start n=%0d: got %b expected %b", n, start, oh(w));
      end
      rr_model = (w + 1) % N;
      if (prev >= 0) begin
        checks++;
        if (ls - prev !== D + 3) begin errors++; $display("[TB] FAIL b2b_period n=%0d: got %0d expected %0d", n, ls - prev, D + 3); end
      end
      prev = ls;
      wait_for_done(ds, seen);
      checks++;
      if (!seen || ds - ls !== D + 1) begin
        errors++;
        $display("[TB] FAIL b2b_latency n=%0d: got %0d expected %0d", n, ds - ls, D + 1);
      end
      checks++;
      if (grant !== oh(w) || err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_grant n=%0d: grant %b err %b expected %b, 0", n, grant, err, oh(w));
      end
    end
    req = '0;
  endtask

  task automatic test_single();
    int  ls, arr, dn;
    bit  seen;
    req = 4'b0001;
    wait_for_start(ls, seen);
    checks++;
    if (!seen || start !== 4'b0001 || grant !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_launch: start %b grant %b expected 0001", start, grant);
    end
    rr_model = 1;
    req = '0;
    arr = -1;
    dn  = -1;
    for (int i = 0; i < 30 && dn < 0; i++) begin
      tick();
      if (chain_out[0] && arr < 0) arr = cyc;
      if (done) dn = cyc;
    end
    checks++;
    if (arr - ls !== D) begin errors++; $display("[TB] FAIL single_arrival: got %0d expected %0d", arr - ls, D); end
    checks++;
    if (dn - ls !== D + 1) begin errors++; $display("[TB] FAIL single_done: got %0d expected %0d", dn - ls, D + 1); end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_after: done %b busy %b err %b expected 0 0 0", done, busy, err);
    end
  endtask

  task automatic test_random();
    int  ls, ds;
    bit  seen;
    for (int n = 0; n < 12; n++) begin
      int w;
      req = '0;
      repeat ($urandom_range(0, 3)) tick();
      req = N'($urandom_range(1, (1 << N) - 1));
      w = rr_pick(req, rr_model);
      wait_for_start(ls, seen);
      checks++;
      if (!seen || start !== oh(w)) begin
        errors++;
        $display("[TB] FAIL rand_start n=%0d req=%b: got %b expected %b", n, req, start, oh(w));
      end
      rr_model = (w + 1) % N;
      tick();
      req = N'($urandom_range(0, (1 << N) - 1));
      tick();
      checks++;
      if (grant !== oh(w)) begin errors++; $display("[TB] FAIL rand_grant_hold n=%0d: got %b expected %b", n, grant, oh(w)); end
      wait_for_done(ds, seen);
      checks++;
      if (!seen || ds - ls !== D + 1 || err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rand_done n=%0d: latency %0d err %b expected %0d, 0", n, ds - ls, err, D + 1);
      end
    end
    req = '0;
  endtask

  task automatic test_stuck();
    int  ls, ea, dn;
    bit  seen;
    stuck_mask = '0;
    stuck_mask[2*S + 2] = 1'b1;
    req = 4'b0100;
    wait_for_start(ls, seen);
    checks++;
    if (!seen || start !== 4'b0100) begin errors++; $display("[TB] FAIL stuck_start: got %b expected 0100", start); end
    rr_model = 3;
    req = '0;
    ea = -1;
    dn = 0;
    for (int i = 0; i < 30 && ea < 0; i++) begin
      tick();
      if (done) dn++;
      if (err) ea = cyc;
    end
    checks++;
    if (ea - ls !== TO + 1 || dn !== 0) begin
      errors++;
      $display("[TB] FAIL stuck_timeout: err after %0d done %0d expected %0d, 0", ea - ls, dn, TO + 1);
    end
    checks++;
    if (err_chain !== 2'd2 || stage_rst !== '1 || grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stuck_err_state: chain %0d stage_rst %h grant %b busy %b expected 2 all ones 0 0", err_chain, stage_rst, grant, busy);
    end
    repeat (3) tick();
    checks++;
    if (err !== 1'b1) begin errors++; $display("[TB] FAIL stuck_sticky: got %b expected 1", err); end
    stuck_mask = '0;
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL err_clear: err %b busy %b expected 0 1", err, busy); end
    repeat (H + S) tick();
    checks++;
    if (busy !== 1'b0 || stage_rst !== '0) begin errors++; $display("[TB] FAIL rearm_ready: busy %b stage_rst %h expected 0 0", busy, stage_rst); end
  endtask

  task automatic test_foreign();
    int  ls;
    bit  seen;
    req = 4'b1000;
    wait_for_start(ls, seen);
    checks++;
    if (!seen || start !== 4'b1000) begin errors++; $display("[TB] FAIL foreign_start: got %b expected 1000", start); end
    rr_model = 0;
    req = '0;
    repeat (3) tick();
    checks++;
    if (err !== 1'b0) begin errors++; $display("[TB] FAIL foreign_pre: err got %b expected 0", err); end
    inj = 4'b0010;
    tick();
    inj = '0;
    checks++;
    if (err !== 1'b1 || err_chain !== 2'd3) begin
      errors++;
      $display("[TB] FAIL foreign_err: err %b chain %0d expected 1, 3", err, err_chain);
    end
    restart_sequence();
  endtask

  task automatic test_reset_mid();
    int  ls, ds, bad;
    bit  seen;
    req = 4'b0001;
    wait_for_start(ls, seen);
    req = '0;
    repeat (3) tick();
    #2;
    rst1 = 1'b1;
    #1;
    checks++;
    if (stage_rst !== '1 || start !== '0 || grant !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_vectors: stage_rst %h start %b grant %b expected all ones 0 0", stage_rst, start, grant);
    end
    checks++;
    if ({busy, done, err} !== 3'b000 || err_chain !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_flags: busy/done/err %b chain %0d expected 000, 0", {busy, done, err}, err_chain);
    end
    tick();
    rst1 = 1'b0;
    rr_model = 0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || err || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL midrst_quiet: got %0d active cycles expected 0", bad); end
    restart_sequence();
    req = 4'b1001;
    wait_for_start(ls, seen);
    checks++;
    if (!seen || start !== oh(rr_pick(4'b1001, rr_model))) begin
      errors++;
      $display("[TB] FAIL midrst_rr: got %b expected %b", start, oh(rr_pick(4'b1001, rr_model)));
    end
    req = '0;
    wait_for_done(ds, seen);
    checks++;
    if (!seen || ds - ls !== D + 1 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_done: latency %0d err %b expected %0d, 0", ds - ls, err, D + 1);
    end
  endtask

  // Watchdog so a hung DUT still terminates the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    test_reset();
    test_sequence();
    test_back_to_back();
    test_single();
    test_random();
    test_stuck();
    test_foreign();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
